// File: rtl/fb_access_arbiter.sv
// Framebuffer SRAM access arbiter: shares one single-port SRAM between the
// layer compositor (writes) and the VGA line prefetcher (reads). One access
// per cycle, registered SRAM pins, fixed-latency read return pipeline.
module fb_access_arbiter #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 24,
   parameter int FB_WORDS = 307200,
   parameter int SRAM_LAT = 2,
   parameter int RUN_MAX  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_urgent,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              err_oob
);

   localparam int CNT_W = 8;
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(FB_WORDS);
   localparam logic [CNT_W-1:0]  RUN_LIMIT  = CNT_W'(RUN_MAX);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_RD,
      OWN_WR
   } owner_t;

   owner_t              owner_reg, owner_next;
   logic [CNT_W-1:0]    run_cnt_reg, run_cnt_next;
   logic                grant_rd, grant_wr;
   logic                run_open;
   logic                rd_oob, wr_oob;
   logic [SRAM_LAT:0]   pipe_valid_reg;
   logic [SRAM_LAT:0]   pipe_oob_reg;

   assign rd_oob   = (rd_addr >= ADDR_LIMIT);
   assign wr_oob   = (wr_addr >= ADDR_LIMIT);
   assign run_open = (run_cnt_reg < RUN_LIMIT);
   assign rd_ack   = grant_rd;
   assign wr_ack   = grant_wr;

   // Grant decision: urgency first, then sole requester, then run-length sharing.
   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (rd_req && rd_urgent) begin
         grant_rd = 1'b1;
      end else if (rd_req && !wr_req) begin
         grant_rd = 1'b1;
      end else if (wr_req && !rd_req) begin
         grant_wr = 1'b1;
      end else if (rd_req && wr_req) begin
         case (owner_reg)
            OWN_RD: begin
               if (run_open) grant_rd = 1'b1;
               else          grant_wr = 1'b1;
            end
            OWN_WR: begin
               if (run_open) grant_wr = 1'b1;
               else          grant_rd = 1'b1;
            end
            default: grant_rd = 1'b1;
         endcase
      end
   end

   // Next owner and run length; the run only counts while the other side waits.
   always_comb begin
      owner_next   = OWN_NONE;
      run_cnt_next = '0;
      if (grant_rd)      owner_next = OWN_RD;
      else if (grant_wr) owner_next = OWN_WR;
      if ((grant_rd && wr_req) || (grant_wr && rd_req)) begin
         if (owner_next != owner_reg) run_cnt_next = CNT_W'(1);
         else if (run_open)           run_cnt_next = run_cnt_reg + 1'b1;
         else                         run_cnt_next = run_cnt_reg;
      end
   end

   // Owner state register and run counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_reg   <= OWN_NONE;
         run_cnt_reg <= '0;
      end else begin
         owner_reg   <= owner_next;
         run_cnt_reg <= run_cnt_next;
      end
   end

   // SRAM command pins; out-of-range accesses are acked but never reach the SRAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_en <= (grant_rd && !rd_oob) || (grant_wr && !wr_oob);
         sram_we <= grant_wr && !wr_oob;
         if (grant_wr && !wr_oob) begin
            sram_addr  <= wr_addr;
            sram_wdata <= wr_data;
         end else if (grant_rd && !rd_oob) begin
            sram_addr  <= rd_addr;
         end
      end
   end

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_oob <= 1'b0;
      end else if ((grant_rd && rd_oob) || (grant_wr && wr_oob)) begin
         err_oob <= 1'b1;
      end
   end

   // Read tracking pipeline: stage k is the read issued k+1 cycles before sampling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_valid_reg <= '0;
         pipe_oob_reg   <= '0;
      end else begin
         pipe_valid_reg <= {pipe_valid_reg[SRAM_LAT-1:0], grant_rd};
         pipe_oob_reg   <= {pipe_oob_reg[SRAM_LAT-1:0], grant_rd && rd_oob};
      end
   end

   // Read return: capture SRAM data (or zero for out-of-range reads) in order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= pipe_valid_reg[SRAM_LAT];
         if (pipe_valid_reg[SRAM_LAT]) begin
            rd_data <= pipe_oob_reg[SRAM_LAT] ? '0 : sram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Testbench for fb_access_arbiter: vector table for arbitration, hand-written
// sequences for latency, contention, urgency, out-of-range, ordering and reset,
// with a read-return scoreboard and an SRAM behavioural model.
module tb_fb_access_arbiter;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 24;
   localparam int FB_WORDS = 307200;
   localparam int SRAM_LAT = 2;
   localparam int RUN_MAX  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_req = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ack;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              rd_urgent = 1'b0;
   logic              rd_ack;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              err_oob;

   fb_access_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS),
      .SRAM_LAT(SRAM_LAT), .RUN_MAX(RUN_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_urgent(rd_urgent), .rd_ack(rd_ack),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .err_oob(err_oob)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
      return {a, 5'b0} ^ 24'h5A5A5A;
   endfunction

   // SRAM model: pins stable at negedge; read data presented for the DUT's sampling edge
   logic [DATA_W-1:0] sram_mem [int];
   logic [DATA_W-1:0] rpipe [SRAM_LAT+1];
   assign sram_rdata = rpipe[SRAM_LAT];

   function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
      if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
      return init_val(a);
   endfunction

   initial begin
      for (int i = 0; i <= SRAM_LAT; i++) rpipe[i] = 24'hBADBAD;
   end

   always @(negedge clk) begin
      for (int i = SRAM_LAT; i > 0; i--) rpipe[i] = rpipe[i-1];
      rpipe[0] = (sram_en && !sram_we) ? model_read(sram_addr) : 24'hBADBAD;
      if (sram_en && sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
   end

   // Expected memory contents as seen by acknowledged requests
   logic [DATA_W-1:0] exp_mem [int];
   function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
      if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
      return init_val(a);
   endfunction

   typedef struct {
      logic [DATA_W-1:0] data;
      int                due;
   } sb_t;
   sb_t sb[$];

   int                pend_kind = 0;   // 0 none, 1 write, 2 read
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_wdata;

   // Monitor: SRAM pins one cycle after each ack, read returns via scoreboard
   always @(negedge clk) begin
      sb_t e;
      if (!rst) begin
         pend_kind = 0;
         sb.delete();
      end else begin
         chk("sram_en", 32'(sram_en), 32'(pend_kind != 0));
         if (pend_kind != 0) begin
            chk("sram_we", 32'(sram_we), 32'(pend_kind == 1));
            chk("sram_addr", 32'(sram_addr), 32'(pend_addr));
         end
         if (pend_kind == 1) chk("sram_wdata", 32'(sram_wdata), 32'(pend_wdata));
         if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("rd_valid_missing", 32'(0), 32'(1));
            void'(sb.pop_front());
         end
         if (rd_valid) begin
            if (sb.size() == 0) begin
               chk("rd_valid_unexpected", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e.data));
               chk("rd_valid_cycle", 32'(cyc), 32'(e.due));
            end
         end
         chk("single_ack", 32'(wr_ack & rd_ack), 32'(0));
         pend_kind = 0;
         if (wr_ack && (int'(wr_addr) < FB_WORDS)) begin
            pend_kind  = 1;
            pend_addr  = wr_addr;
            pend_wdata = wr_data;
            exp_mem[int'(wr_addr)] = wr_data;
         end
         if (rd_ack) begin
            e.due  = cyc + 2 + SRAM_LAT;
            e.data = (int'(rd_addr) < FB_WORDS) ? exp_read(rd_addr) : '0;
            sb.push_back(e);
            if (int'(rd_addr) < FB_WORDS) begin
               pend_kind = 2;
               pend_addr = rd_addr;
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sram_en"}, 32'(sram_en), 32'(0));
      chk({tag, "_sram_we"}, 32'(sram_we), 32'(0));
      chk({tag, "_sram_addr"}, 32'(sram_addr), 32'(0));
      chk({tag, "_sram_wdata"}, 32'(sram_wdata), 32'(0));
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
      chk({tag, "_rd_data"}, 32'(rd_data), 32'(0));
      chk({tag, "_err_oob"}, 32'(err_oob), 32'(0));
      chk({tag, "_acks"}, 32'({rd_ack, wr_ack}), 32'(0));
   endtask

   typedef struct {
      logic              rd_req;
      logic              rd_urgent;
      logic              wr_req;
      logic [ADDR_W-1:0] rd_addr;
      logic [ADDR_W-1:0] wr_addr;
      logic [DATA_W-1:0] wr_data;
      logic              exp_rd_ack;
      logic              exp_wr_ack;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ta;
      int run_rd;
      int run_wr;
      bit seen;

      // owner starts at NONE after reset; rows are consecutive cycles
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 19'h00010, 19'h00020, 24'h111111, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 19'h00011, 19'h00010, 24'h222222, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 19'h00012, 19'h00021, 24'h333333, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 19'h00010, 19'h00022, 24'h444444, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 19'h00021, 19'h00022, 24'h444444, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h00000, 24'h000000, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 19'h00022, 19'h00023, 24'h555555, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 19'h00022, 19'h00023, 24'h555555, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 19'h00030, 19'h00031, 24'h666666, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 19'h00030, 19'h00031, 24'h666666, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 19'h00031, 19'h00032, 24'h777777, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h00000, 24'h000000, 1'b0, 1'b0};

      // reset state
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      tick(); rst = 1'b1;
      tick();

      // arbitration vectors
      for (int i = 0; i < 12; i++) begin
         rd_req = vecs[i].rd_req; rd_urgent = vecs[i].rd_urgent; wr_req = vecs[i].wr_req;
         rd_addr = vecs[i].rd_addr; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         @(negedge clk);
         chk($sformatf("vec%0d_rd_ack", i), 32'(rd_ack), 32'(vecs[i].exp_rd_ack));
         chk($sformatf("vec%0d_wr_ack", i), 32'(wr_ack), 32'(vecs[i].exp_wr_ack));
         tick();
      end
      rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
      tick();

      // single read latency
      rd_req = 1'b1; rd_addr = 19'h00123;
      @(negedge clk); chk("lat_rd_ack", 32'(rd_ack), 32'(1)); ta = cyc;
      tick(); rd_req = 1'b0;
      @(negedge clk);
      chk("lat_sram_en", 32'(sram_en), 32'(1));
      chk("lat_sram_we", 32'(sram_we), 32'(0));
      chk("lat_sram_addr", 32'(sram_addr), 32'h00123);
      tick(); @(negedge clk); chk("lat_early2", 32'(rd_valid), 32'(0));
      tick(); @(negedge clk); chk("lat_early3", 32'(rd_valid), 32'(0));
      tick(); @(negedge clk);
      chk("lat_valid4", 32'(rd_valid), 32'(1));
      chk("lat_data4", 32'(rd_data), 32'(init_val(19'h00123)));
      chk("lat_cycle", 32'(cyc - ta), 32'(4));
      tick(); @(negedge clk); chk("lat_single_pulse", 32'(rd_valid), 32'(0));
      tick();

      // contention: both held, no urgency -> alternating runs of RUN_MAX
      rd_req = 1'b1; wr_req = 1'b1; rd_addr = 19'h00200; wr_addr = 19'h00300; wr_data = 24'hABCDEF;
      run_rd = 0; run_wr = 0;
      for (int i = 0; i < 6 * RUN_MAX; i++) begin
         @(negedge clk);
         chk($sformatf("cont%0d_rd_ack", i), 32'(rd_ack), 32'(((i / RUN_MAX) % 2) == 0));
         chk($sformatf("cont%0d_wr_ack", i), 32'(wr_ack), 32'(((i / RUN_MAX) % 2) == 1));
         run_rd = rd_ack ? run_rd + 1 : 0;
         run_wr = wr_ack ? run_wr + 1 : 0;
         if (run_rd > RUN_MAX || run_wr > RUN_MAX)
            chk("cont_run_limit", 32'(run_rd > run_wr ? run_rd : run_wr), 32'(RUN_MAX));
         tick();
      end
      rd_req = 1'b0; wr_req = 1'b0;
      tick();

      // urgent override: reads hold the SRAM; write follows once urgency drops
      rd_req = 1'b1; wr_req = 1'b1; rd_urgent = 1'b1; rd_addr = 19'h00210; wr_addr = 19'h00310;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("urg%0d_rd_ack", i), 32'(rd_ack), 32'(1));
         chk($sformatf("urg%0d_wr_ack", i), 32'(wr_ack), 32'(0));
         tick();
      end
      rd_urgent = 1'b0;
      @(negedge clk);
      chk("urg_release_wr_ack", 32'(wr_ack), 32'(1));
      chk("urg_release_rd_ack", 32'(rd_ack), 32'(0));
      tick(); rd_req = 1'b0; wr_req = 1'b0;
      tick();

      // out-of-range handling
      @(negedge clk); chk("oob_pre_err", 32'(err_oob), 32'(0));
      tick(); wr_req = 1'b1; wr_addr = 19'h4B000; wr_data = 24'h123456;
      @(negedge clk); chk("oob_wr_ack", 32'(wr_ack), 32'(1));
      tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 19'h4AFFF;
      @(negedge clk);
      chk("oob_wr_no_access", 32'(sram_en), 32'(0));
      chk("oob_err_set", 32'(err_oob), 32'(1));
      chk("edge_rd_ack", 32'(rd_ack), 32'(1));
      tick(); rd_addr = 19'h7FFFF;
      @(negedge clk);
      chk("oob_rd_ack", 32'(rd_ack), 32'(1)); ta = cyc;
      chk("edge_rd_sram_en", 32'(sram_en), 32'(1));
      chk("edge_rd_sram_addr", 32'(sram_addr), 32'h4AFFF);
      tick(); rd_req = 1'b0;
      @(negedge clk); chk("oob_rd_no_access", 32'(sram_en), 32'(0));
      tick(); tick(); tick();
      @(negedge clk);
      chk("oob_rd_valid", 32'(rd_valid), 32'(1));
      chk("oob_rd_data", 32'(rd_data), 32'(0));
      chk("oob_rd_cycle", 32'(cyc - ta), 32'(4));
      chk("oob_err_sticky", 32'(err_oob), 32'(1));
      tick();

      // write then read of the same address
      wr_req = 1'b1; wr_addr = 19'h00500; wr_data = 24'hCCFF99;
      @(negedge clk); chk("wtr_wr_ack", 32'(wr_ack), 32'(1));
      tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 19'h00500;
      @(negedge clk); chk("wtr_rd_ack", 32'(rd_ack), 32'(1)); ta = cyc;
      tick(); rd_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rd_valid) begin
            seen = 1'b1;
            chk("wtr_rd_data", 32'(rd_data), 32'hCCFF99);
            chk("wtr_cycle", 32'(cyc - ta), 32'(4));
         end
         tick();
      end
      if (!seen) chk("wtr_timeout", 32'(0), 32'(1));
      tick();

      // reset in the middle of two outstanding reads
      rd_req = 1'b1; rd_addr = 19'h00040;
      @(negedge clk); chk("rst_rd0_ack", 32'(rd_ack), 32'(1));
      tick(); rd_addr = 19'h00041;
      @(negedge clk); chk("rst_rd1_ack", 32'(rd_ack), 32'(1));
      tick(); rd_req = 1'b0; rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_all_zero($sformatf("midrst%0d", i));
         tick();
      end
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("postrst%0d_rd_valid", i), 32'(rd_valid), 32'(0));
         tick();
      end

      // all expected read returns must have arrived
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("sb_drain", 32'(sb.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares the single-port 640x480 framebuffer SRAM between two requesters.
- The layer compositor writes composited pixels; the VGA line prefetcher reads pixels for scan-out.
- Issues at most one SRAM access per cycle and returns read data through a fixed-latency pipeline.
- Read priority escalates when the display FIFO runs low; otherwise a bounded run-length scheme prevents either side from starving the other.

Parameters:
ADDR_W, 19, framebuffer word address width
DATA_W, 24, pixel width (RGB888)
FB_WORDS, 307200, valid address range 0..FB_WORDS-1 (640*480)
SRAM_LAT, 2, cycles from command visible on SRAM pins to sram_rdata valid (1..4)
RUN_MAX, 8, max consecutive grants to one requester while the other is requesting (2..255)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
wr_req  in  1  compositor write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
wr_ack  out  1  combinational; high in the cycle the write is accepted
rd_req  in  1  prefetcher read request
rd_addr  in  ADDR_W  read address
rd_urgent  in  1  display FIFO below low-water mark
rd_ack  out  1  combinational; high in the cycle the read is accepted
rd_data  out  DATA_W  returned pixel, registered
rd_valid  out  1  registered; one pulse per accepted read
sram_en  out  1  registered SRAM access strobe
sram_we  out  1  registered; 1=write, 0=read
sram_addr  out  ADDR_W  registered SRAM address
sram_wdata  out  DATA_W  registered SRAM write data
sram_rdata  in  DATA_W  SRAM read data
err_oob  out  1  sticky; set by any out-of-range accepted request

Behaviour:
- Reset (rst=0, async): all registered outputs 0; owner=NONE; run_cnt=0; read pipeline flushed, so in-flight reads produce no rd_valid. Outputs stay 0 for the whole reset assertion.
- Owner FSM, states NONE / RD / WR; at most one ack per cycle. Decision priority, evaluated combinationally from reqs and registered state:
  1. rd_req & rd_urgent: grant RD.
  2. Only one req: grant it.
  3. Both reqs: grant current owner if run_cnt < RUN_MAX, else the other; from NONE, RD wins.
  4. No req: no grant, owner -> NONE.
- run_cnt:
  - Increments on each grant to the same owner while the other requests.
  - Reset to 1 on an owner switch.
  - Reset to 0 when the other stops requesting or when owner -> NONE.
  - Saturates at RUN_MAX.
  - Urgent grants also count, but urgency overrides the limit, so writes may starve while rd_urgent stays high. This is intended.
- Write path: ack at cycle t; sram_en=1, sram_we=1, addr and wdata visible in cycle t+1.
- Read path: ack at cycle t; sram_en=1, sram_we=0 in cycle t+1; sram_rdata sampled at end of cycle t+1+SRAM_LAT; rd_valid=1 and rd_data valid in cycle t+2+SRAM_LAT.
  - Reads complete in acceptance order.
  - Back-to-back reads give back-to-back rd_valid pulses. The pipeline is a SRAM_LAT+1 deep shift register of valid and oob bits.
- No grant in a cycle: sram_en=0 next cycle; sram_addr and sram_wdata hold their previous values.
- Out of range (addr >= FB_WORDS):
  - Request is still acked; err_oob is set and stays set until reset.
  - OOB write: no SRAM access (sram_en=0).
  - OOB read: no SRAM access; rd_valid still pulses at the normal latency with rd_data=0.
- Ordering: a write acked before a read to the same address reaches the SRAM first, so the read returns the new data. No bypass logic is needed.
- Requesters hold req, addr and data stable until acked; changes without an ack are permitted and ignored.

Test Plan:
- Reset mid-stream: reads acked at cycles 10,11 with SRAM_LAT=2; rst=0 at cycle 12 -> no rd_valid pulses; all outputs 0 during reset; err_oob cleared.
- Single read latency: rd_req at addr 0x00123 acked at t -> sram_en=1, sram_we=0, sram_addr=0x00123 at t+1; rd_data = value driven on sram_rdata at t+3, rd_valid pulse at t+4.
- Contention, RUN_MAX=8, both reqs held high, no urgent -> grants RD x8, WR x8, RD x8...; never 9 consecutive grants to one side.
- Urgent override: both reqs high, rd_urgent=1 for 20 cycles -> 20 consecutive RD acks, zero wr_ack; rd_urgent drops -> WR granted within 1 cycle.
- OOB: write to 0x4B000 -> wr_ack=1, no sram_en, err_oob=1. Read to 0x4AFFF -> normal SRAM access. Read to 0x7FFFF -> rd_valid with rd_data=0 at t+4.
- Write-then-read: write 0xCCFF99 to 0x00500 then read 0x00500 on the next cycle, with an SRAM model -> rd_data=0xCCFF99.
